mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DEPTH, 1024, data RAM depth in 32-bit words (power of two, 16..65536).
REQ-002 Parameter WAIT_CYCLES, 2, extra wait states per RAM access (0..15).
REQ-003 Derived constant ADDR_W = log2(DEPTH)+2, the number of byte-address bits used.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  request present.
REQ-007 in_ready  out  1  unit accepts a request this cycle.
REQ-008 alu_result  in  32  byte address for memory ops; write-back value for non-memory ops.
REQ-009 wdata  in  32  store data, right-aligned.
REQ-010 pc_plus_4  in  32  link value for jal.
REQ-011 mode  in  2  access size: 00 word, 01 half, 10 byte, 11 reserved.
REQ-012 we, re, sign_ext, jal  in  1 each  store, load, sign-extend load, link select.
REQ-013 out_valid  out  1  write-back result valid.
REQ-014 out_ready  in  1  consumer takes result.
REQ-015 wb_data  out  32  register-file write data.
REQ-016 fault  out  1  misaligned or illegal request; qualifies out_valid.

Function
REQ-017 FSM states IDLE, WAIT, RESP; in_ready = 1 only in IDLE.
REQ-018 Accept when in_valid && in_ready; all request fields latched on acceptance.
REQ-019 Non-memory request (we=re=0): RESP next cycle with wb_data = jal ? pc_plus_4 : alu_result, fault=0.
REQ-020 Illegal request: we&&re, mode=11 with we|re, half with addr[0]=1, word with addr[1:0]!=0 -> RESP next cycle, fault=1, wb_data=0, RAM untouched.
REQ-021 Legal memory request: WAIT with counter=WAIT_CYCLES, decrement per cycle; access issued at counter 0; out_valid exactly WAIT_CYCLES+2 cycles after acceptance.
REQ-022 Word index = alu_result[ADDR_W-1:2]; upper address bits ignored (wrap modulo DEPTH).
REQ-023 Store: byte enables from mode and addr[1:0] (byte: one lane; half: lanes {1,0} or {3,2}; word: all); wdata low bytes replicated into selected lanes; unselected bytes preserved; store completes with wb_data = alu_result.
REQ-024 Load: lane(s) selected by addr[1:0]; sign_ext=1 sign-extends, else zero-extends; word loads unaffected.
REQ-025 RESP: out_valid=1, wb_data/fault stable while out_ready=0; on out_ready=1 return to IDLE next cycle.
REQ-026 Store visible to any load accepted after the store's out_valid handshake.
REQ-027 in_valid during WAIT/RESP ignored (no acceptance, no state change).
REQ-028 WAIT_CYCLES=0: access in the cycle after acceptance; latency 2.

Reset
REQ-029 rst low, any state: asynchronously to IDLE, counter 0, out_valid 0, wb_data 0, fault 0, in_ready 1 after deassertion.
REQ-030 Reset during WAIT aborts the request; an in-flight store does not modify RAM.
REQ-031 RAM contents not reset; undefined until written.

Structure
REQ-032 Package mem_pkg holds mode encodings, FSM state type, and byte-enable/extend helper functions.
REQ-033 One sub-module mem_bank: DEPTH x 32 synchronous RAM, 4 byte-write enables, registered read.
REQ-034 All outputs registered; no combinational path from in_* to out_* or in_ready.

Verification
REQ-035 WAIT_CYCLES=2: word store 0xDEADBEEF @0x010, then word load @0x010 -> wb_data 0xDEADBEEF, out_valid 4 cycles after each accept.
REQ-036 Byte store 0x80 @0x013 over 0x00000000, byte load sign_ext=1 -> 0xFFFFFF80; sign_ext=0 -> 0x00000080; word load -> 0x80000000.
REQ-037 Half load @0x011 -> fault=1, wb_data 0, latency 2; word @0x012 -> fault; subsequent word load unchanged.
REQ-038 jal=1, we=re=0, pc_plus_4=0x00000404 -> wb_data 0x00000404, latency 2; out_ready held 0 five cycles -> wb_data stable, in_ready 0.
REQ-039 Store accepted, rst low during WAIT -> outputs zero, IDLE; later load of that address returns prior value.
REQ-040 WAIT_CYCLES=0, DEPTH=16: store @0x040 aliases @0x000; load @0x000 returns stored data, latency 2.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: access-size encodings, FSM state type and lane helpers for mem_access_unit
package mem_pkg;

    localparam logic [1:0] MODE_WORD = 2'b00;
    localparam logic [1:0] MODE_HALF = 2'b01;
    localparam logic [1:0] MODE_BYTE = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    function automatic logic [3:0] byte_en(input logic [1:0] mode, input logic [1:0] a);
        return mode == MODE_WORD ? 4'hF :
               mode == MODE_HALF ? (a[1] ? 4'hC : 4'h3) :
               mode == MODE_BYTE ? 4'b0001 << a : 4'h0;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] mode, input logic [31:0] d);
        return mode == MODE_WORD ? d :
               mode == MODE_HALF ? {2{d[15:0]}} : {4{d[7:0]}};
    endfunction

    function automatic logic [31:0] load_extend(input logic [1:0] mode, input logic [1:0] a,
                                                input logic sx, input logic [31:0] w);
        logic [31:0] s;
        s = w >> {a, 3'b000};
        return mode == MODE_WORD ? w :
               mode == MODE_HALF ? {{16{sx & s[15]}}, s[15:0]} : {{24{sx & s[7]}}, s[7:0]};
    endfunction

    function automatic logic illegal(input logic we, input logic re, input logic [1:0] mode,
                                     input logic [1:0] a);
        return (we & re) | ((we | re) & ((mode == MODE_RSVD) |
               (mode == MODE_HALF & a[0]) | (mode == MODE_WORD & a != 2'b00)));
    endfunction

endpackage

// File: rtl/mem_bank.sv
// mem_bank: DEPTH x 32 synchronous RAM with per-byte write enables and registered read
module mem_bank #(
    parameter int DEPTH = 1024,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    // write selected lanes and capture the old word on every enabled access
    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int b = 0; b < 4; b++)
                if (be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            rdata_o <= mem_q[addr_i];
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store/write-back stage with wait states, alignment checks and a byte-lane RAM
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_result,
    input  logic [31:0] wdata,
    input  logic [31:0] pc_plus_4,
    input  logic [1:0]  mode,
    input  logic        we,
    input  logic        re,
    input  logic        sign_ext,
    input  logic        jal,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] wb_data,
    output logic        fault
);

    localparam int ADDR_W = $clog2(DEPTH) + 2;

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic              issued_q, mem_q, st_q, sx_q, fault_q, out_valid_q;
    logic [1:0]        mode_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdat_q, wb_q, rdata;
    logic              req_bad, req_mem, acc;

    assign req_bad   = illegal(we, re, mode, alu_result[1:0]);
    assign req_mem   = (we | re) & ~req_bad;
    assign acc       = state_q == S_WAIT && cnt_q == 4'd0 && !issued_q && mem_q;
    assign in_ready  = state_q == S_IDLE;
    assign out_valid = out_valid_q;
    assign wb_data   = wb_q;
    assign fault     = fault_q;

    mem_bank #(.DEPTH(DEPTH)) u_bank (
        .clk    (clk),
        .en_i   (acc),
        .be_i   (st_q ? byte_en(mode_q, addr_q[1:0]) : 4'h0),
        .addr_i (addr_q[ADDR_W-1:2]),
        .wdata_i(wdat_q),
        .rdata_o(rdata)
    );

    // request FSM: every request spends one access slot in WAIT after its wait states, then RESP
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            issued_q    <= 1'b0;
            mem_q       <= 1'b0;
            st_q        <= 1'b0;
            sx_q        <= 1'b0;
            mode_q      <= MODE_WORD;
            addr_q      <= '0;
            wdat_q      <= '0;
            wb_q        <= '0;
            fault_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (in_valid) begin
                    state_q  <= S_WAIT;
                    cnt_q    <= req_mem ? 4'(WAIT_CYCLES) : 4'd0;
                    issued_q <= 1'b0;
                    mem_q    <= req_mem;
                    st_q     <= we;
                    sx_q     <= sign_ext;
                    mode_q   <= mode;
                    addr_q   <= alu_result[ADDR_W-1:0];
                    wdat_q   <= store_lanes(mode, wdata);
                    fault_q  <= req_bad;
                    wb_q     <= req_bad ? 32'd0 : (jal && !(we | re)) ? pc_plus_4 : alu_result;
                end
                S_WAIT: begin
                    if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
                    else if (!issued_q) issued_q <= 1'b1;
                    else begin
                        state_q     <= S_RESP;
                        out_valid_q <= 1'b1;
                        if (mem_q && !st_q) wb_q <= load_extend(mode_q, addr_q[1:0], sx_q, rdata);
                    end
                end
                S_RESP: if (out_ready) begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for two mem_access_unit configurations
module tb_mem_access_unit;

    typedef struct {
        int          u;
        logic [31:0] wb;
        logic        f;
        int          lat;
        longint      tacc;
        string       nm;
    } exp_t;

    exp_t sb[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst[2], in_valid[2], in_ready[2], out_valid[2], out_ready[2], fault[2];
    logic        we[2], re[2], sign_ext[2], jal[2], busy[2];
    logic [31:0] alu[2], wdata[2], pc[2], wb[2];
    logic [1:0]  mode[2];
    int          n_chk = 0, n_fail = 0;

    mem_access_unit #(.DEPTH(1024), .WAIT_CYCLES(2)) u0 (
        .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .alu_result(alu[0]), .wdata(wdata[0]), .pc_plus_4(pc[0]), .mode(mode[0]),
        .we(we[0]), .re(re[0]), .sign_ext(sign_ext[0]), .jal(jal[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .wb_data(wb[0]), .fault(fault[0])
    );

    mem_access_unit #(.DEPTH(16), .WAIT_CYCLES(0)) u1 (
        .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .alu_result(alu[1]), .wdata(wdata[1]), .pc_plus_4(pc[1]), .mode(mode[1]),
        .we(we[1]), .re(re[1]), .sign_ext(sign_ext[1]), .jal(jal[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .wb_data(wb[1]), .fault(fault[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    // monitor: compare every presented response against the head of the scoreboard
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (!rst[u]) busy[u] = 1'b0;
            else if (out_valid[u]) begin
                if (sb.size() == 0 || sb[0].u != u) begin
                    chk($sformatf("u%0d unexpected out_valid", u), 32'(out_valid[u]), 32'd0);
                end else begin
                    chk({sb[0].nm, " in_ready"}, 32'(in_ready[u]), 32'd0);
                    chk({sb[0].nm, " wb_data"}, wb[u], sb[0].wb);
                    chk({sb[0].nm, " fault"}, 32'(fault[u]), 32'(sb[0].f));
                    if (!busy[u]) chk({sb[0].nm, " latency"}, 32'(($time - 5 - sb[0].tacc) / 10), 32'(sb[0].lat));
                    busy[u] = 1'b1;
                    if (out_ready[u]) begin
                        busy[u] = 1'b0;
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    task automatic issue(input int u, input logic [31:0] a, input logic [31:0] wd, input logic [31:0] p,
                         input logic [1:0] md, input logic w, input logic r, input logic sx, input logic j,
                         input logic [31:0] ewb, input logic ef, input int elat, input string nm,
                         input int hold);
        exp_t e;
        int   n;
        n = 0;
        while (!in_ready[u] && n < 50) begin @(posedge clk); #1; n++; end
        if (!in_ready[u]) begin
            n_chk++; n_fail++;
            $display("FAIL %s: in_ready timeout got 0 expected 1", nm);
            return;
        end
        alu[u] = a; wdata[u] = wd; pc[u] = p; mode[u] = md;
        we[u] = w; re[u] = r; sign_ext[u] = sx; jal[u] = j; in_valid[u] = 1'b1;
        @(posedge clk);
        e.u = u; e.wb = ewb; e.f = ef; e.lat = elat; e.tacc = $time; e.nm = nm;
        sb.push_back(e);
        #1;
        in_valid[u] = 1'b0; alu[u] = ~a; wdata[u] = ~wd; pc[u] = ~p; sign_ext[u] = ~sx;
        if (hold > 0) begin
            out_ready[u] = 1'b0;
            n = 0;
            while (!out_valid[u] && n < 50) begin @(posedge clk); #1; n++; end
            in_valid[u] = 1'b1;
            repeat (hold) begin @(posedge clk); #1; end
            in_valid[u] = 1'b0;
            out_ready[u] = 1'b1;
        end
        n = 0;
        while (sb.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
        if (sb.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL %s: response timeout got none expected %08h", nm, ewb);
            sb.delete();
        end
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b0; in_valid[u] = 1'b0; out_ready[u] = 1'b1; busy[u] = 1'b0;
            alu[u] = '0; wdata[u] = '0; pc[u] = '0; mode[u] = 2'b00;
            we[u] = 1'b0; re[u] = 1'b0; sign_ext[u] = 1'b0; jal[u] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("u%0d reset out_valid", u), 32'(out_valid[u]), 32'd0);
            chk($sformatf("u%0d reset wb_data", u), wb[u], 32'd0);
            chk($sformatf("u%0d reset fault", u), 32'(fault[u]), 32'd0);
            rst[u] = 1'b1;
        end
        @(posedge clk); #1;
        for (int u = 0; u < 2; u++) chk($sformatf("u%0d in_ready after reset", u), 32'(in_ready[u]), 32'd1);

        issue(0, 32'h010, 32'hDEADBEEF, 0, 2'b00, 1, 0, 0, 0, 32'h010, 0, 4, "st_w", 0);
        issue(0, 32'h010, 0, 0, 2'b00, 0, 1, 0, 0, 32'hDEADBEEF, 0, 4, "ld_w", 0);
        issue(0, 32'h010, 32'h0, 0, 2'b00, 1, 0, 0, 0, 32'h010, 0, 4, "st_w0", 0);
        issue(0, 32'h013, 32'hABCDEF80, 0, 2'b10, 1, 0, 0, 0, 32'h013, 0, 4, "st_b", 0);
        issue(0, 32'h013, 0, 0, 2'b10, 0, 1, 1, 0, 32'hFFFFFF80, 0, 4, "ld_b_sx", 0);
        issue(0, 32'h013, 0, 0, 2'b10, 0, 1, 0, 0, 32'h00000080, 0, 4, "ld_b_zx", 0);
        issue(0, 32'h010, 0, 0, 2'b00, 0, 1, 0, 0, 32'h80000000, 0, 4, "ld_w_after_b", 0);
        issue(0, 32'h014, 32'h11111111, 0, 2'b00, 1, 0, 0, 0, 32'h014, 0, 4, "st_w1", 0);
        issue(0, 32'h016, 32'h1234BEEF, 0, 2'b01, 1, 0, 0, 0, 32'h016, 0, 4, "st_h", 0);
        issue(0, 32'h014, 0, 0, 2'b00, 0, 1, 0, 0, 32'hBEEF1111, 0, 4, "ld_w_after_h", 0);
        issue(0, 32'h016, 0, 0, 2'b01, 0, 1, 1, 0, 32'hFFFFBEEF, 0, 4, "ld_h_hi_sx", 0);
        issue(0, 32'h014, 0, 0, 2'b01, 0, 1, 1, 0, 32'h00001111, 0, 4, "ld_h_lo_sx", 0);
        issue(0, 32'h017, 0, 0, 2'b10, 0, 1, 1, 0, 32'hFFFFFFBE, 0, 4, "ld_b3_sx", 0);
        issue(0, 32'h015, 0, 0, 2'b10, 0, 1, 0, 0, 32'h00000011, 0, 4, "ld_b1_zx", 0);

        issue(0, 32'h011, 0, 0, 2'b01, 0, 1, 0, 0, 32'h0, 1, 2, "ld_h_mis", 0);
        issue(0, 32'h012, 0, 0, 2'b00, 0, 1, 0, 0, 32'h0, 1, 2, "ld_w_mis", 0);
        issue(0, 32'h015, 32'hFFFFFFFF, 0, 2'b01, 1, 0, 0, 0, 32'h0, 1, 2, "st_h_mis", 0);
        issue(0, 32'h014, 0, 0, 2'b11, 0, 1, 0, 0, 32'h0, 1, 2, "ld_rsvd", 0);
        issue(0, 32'h014, 32'hFFFFFFFF, 0, 2'b00, 1, 1, 0, 0, 32'h0, 1, 2, "we_re", 0);
        issue(0, 32'h010, 0, 0, 2'b00, 0, 1, 0, 0, 32'h80000000, 0, 4, "ld_w_unchanged", 0);
        issue(0, 32'h014, 0, 0, 2'b00, 0, 1, 0, 0, 32'hBEEF1111, 0, 4, "ld_after_bad_st", 0);

        issue(0, 32'h1234, 0, 32'h404, 2'b00, 0, 0, 0, 1, 32'h00000404, 0, 2, "jal_hold", 5);
        issue(0, 32'hCAFEF00D, 0, 32'h404, 2'b11, 0, 0, 0, 0, 32'hCAFEF00D, 0, 2, "alu_pass", 0);
        issue(0, 32'hFFFFF024, 32'h0BADCAFE, 0, 2'b00, 1, 0, 0, 0, 32'hFFFFF024, 0, 4, "st_wrap", 0);
        issue(0, 32'h024, 0, 0, 2'b00, 0, 1, 0, 0, 32'h0BADCAFE, 0, 4, "ld_wrap", 0);

        issue(0, 32'h020, 32'h55AA55AA, 0, 2'b00, 1, 0, 0, 0, 32'h020, 0, 4, "st_pre_abort", 0);
        begin
            int n;
            n = 0;
            while (!in_ready[0] && n < 50) begin @(posedge clk); #1; n++; end
            alu[0] = 32'h020; wdata[0] = 32'hFFFFFFFF; mode[0] = 2'b00;
            we[0] = 1'b1; re[0] = 1'b0; jal[0] = 1'b0; in_valid[0] = 1'b1;
            @(posedge clk); #1;
            in_valid[0] = 1'b0;
            @(posedge clk); #1;
            rst[0] = 1'b0;
            #1;
            chk("abort out_valid", 32'(out_valid[0]), 32'd0);
            chk("abort wb_data", wb[0], 32'd0);
            chk("abort fault", 32'(fault[0]), 32'd0);
            @(posedge clk); #1;
            rst[0] = 1'b1;
            #1;
            chk("abort in_ready", 32'(in_ready[0]), 32'd1);
        end
        issue(0, 32'h020, 0, 0, 2'b00, 0, 1, 0, 0, 32'h55AA55AA, 0, 4, "ld_after_abort", 0);

        issue(1, 32'h040, 32'hCAFEBABE, 0, 2'b00, 1, 0, 0, 0, 32'h040, 0, 2, "d16_st_alias", 0);
        issue(1, 32'h000, 0, 0, 2'b00, 0, 1, 0, 0, 32'hCAFEBABE, 0, 2, "d16_ld_w", 0);
        issue(1, 32'h002, 0, 0, 2'b10, 0, 1, 0, 0, 32'h000000FE, 0, 2, "d16_ld_b", 0);
        issue(1, 32'h0, 0, 32'h88, 2'b00, 0, 0, 0, 1, 32'h00000088, 0, 2, "d16_jal", 0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
